bht_predictor: RTL and testbench

Parametrised branch history table predictor for the rv32i pipeline, the successor to the single-counter branch predictor FSM. It holds a table of saturating counters indexed by PC, or by PC xor global history. It answers taken/not-taken plus the target address for a branch in decode, and trains on the resolved outcome from the memory stage. It also keeps branch and mispredict statistics for the cycle-count and morse readout path.

---
 rtl/bht_predictor.sv | 109 ++++++++++
 tb/tb_bht_predictor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// Branch history table predictor: a table of saturating counters indexed by
// PC (bimodal) or PC xor global history (gshare). Predicts in decode,
// trains on the resolved outcome in MEM, and counts branches/mispredicts.
module bht_predictor #(
    parameter int IDX_BITS  = 4,
    parameter int CNT_BITS  = 2,
    parameter int INIT_CNT  = 2**(CNT_BITS-1),
    parameter int GSHARE    = 0,
    parameter int STAT_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // decode-stage query
    input  logic                 branch_decode_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          offset_i,
    output logic                 prediction_o,
    output logic [31:0]          branch_addr_o,
    output logic [IDX_BITS-1:0]  query_idx_o,
    // MEM-stage training
    input  logic                 branch_mem_i,
    input  logic                 actual_i,
    input  logic [IDX_BITS-1:0]  update_idx_i,
    input  logic                 update_pred_i,
    // statistics
    output logic [STAT_BITS-1:0] branches_o,
    output logic [STAT_BITS-1:0] mispredicts_o
);

    localparam int                  DEPTH    = 2**IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(INIT_CNT);

    logic [CNT_BITS-1:0]  cnt_q [DEPTH];
    logic [CNT_BITS-1:0]  cnt_d;
    logic [IDX_BITS-1:0]  ghr;
    logic [IDX_BITS-1:0]  idx;
    logic [STAT_BITS-1:0] branches_q;
    logic [STAT_BITS-1:0] mispredicts_q;

    // Global history: a real shift register only in gshare mode.
    generate
        if (GSHARE != 0) begin : g_ghr
            logic [IDX_BITS-1:0] ghr_q;

            // Shift in each resolved outcome; history is never speculative.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ghr_q <= '0;
                end else if (branch_mem_i) begin
                    // Cast keeps the low IDX_BITS, which also covers IDX_BITS=1.
                    ghr_q <= IDX_BITS'({ghr_q, actual_i});
                end
            end

            assign ghr = ghr_q;
        end else begin : g_no_ghr
            assign ghr = '0;
        end
    endgenerate

    // Query path: purely combinational, reads the pre-update table and ghr.
    assign idx           = pc_i[IDX_BITS+1:2] ^ ghr;
    assign query_idx_o   = idx;
    assign prediction_o  = branch_decode_i & cnt_q[idx][CNT_BITS-1];
    assign branch_addr_o = pc_i + offset_i;

    // Saturating step of the counter being trained.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned,
        // which would otherwise infer a latch.
        cnt_d = cnt_q[update_idx_i];
        if (actual_i) begin
            if (cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
        end else begin
            if (cnt_d != '0) cnt_d = cnt_d - 1'b1;
        end
    end

    // Counter table: every entry reset to the weakly-taken value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the table is a register file, not RAM, precisely so that
            // every entry can be cleared by reset; a RAM could not be.
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
        end else if (branch_mem_i) begin
            // NOTE: non-blocking assignment so queries this cycle see the
            // old value (read-before-write) and no race with other blocks.
            cnt_q[update_idx_i] <= cnt_d;
        end
    end

    // Statistics: count resolved branches and mispredictions, wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else if (branch_mem_i) begin
            branches_q <= branches_q + STAT_BITS'(1);
            if (update_pred_i != actual_i) begin
                mispredicts_q <= mispredicts_q + STAT_BITS'(1);
            end
        end
    end

    assign branches_o    = branches_q;
    assign mispredicts_o = mispredicts_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: a bimodal instance (4-bit statistics, to exercise
// wrap) and a gshare instance share one stimulus stream and are compared
// against a behavioural model built from the counter/history rules.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec;
    logic [31:0] pc;
    logic [31:0] off;
    logic        bm;
    logic        act;
    logic [3:0]  uidx;
    logic        upred;

    logic        pred_b, pred_g;
    logic [31:0] addr_b, addr_g;
    logic [3:0]  qidx_b, qidx_g;
    logic [3:0]  br_b, mp_b;
    logic [15:0] br_g, mp_g;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: [0] = bimodal, [1] = gshare.
    int m_cnt [2][16];
    int m_ghr;
    int m_br  [2];
    int m_mp  [2];
    int m_mod [2] = '{16, 65536};

    always #5 clk = ~clk;

    bht_predictor #(.IDX_BITS(4), .CNT_BITS(2), .GSHARE(0), .STAT_BITS(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .branch_decode_i(dec), .pc_i(pc), .offset_i(off),
        .prediction_o(pred_b), .branch_addr_o(addr_b), .query_idx_o(qidx_b),
        .branch_mem_i(bm), .actual_i(act), .update_idx_i(uidx), .update_pred_i(upred),
        .branches_o(br_b), .mispredicts_o(mp_b)
    );

    bht_predictor #(.IDX_BITS(4), .CNT_BITS(2), .GSHARE(1), .STAT_BITS(16)) dut_g (
        .clk_i(clk), .rst_i(rst),
        .branch_decode_i(dec), .pc_i(pc), .offset_i(off),
        .prediction_o(pred_g), .branch_addr_o(addr_g), .query_idx_o(qidx_g),
        .branch_mem_i(bm), .actual_i(act), .update_idx_i(uidx), .update_pred_i(upred),
        .branches_o(br_g), .mispredicts_o(mp_g)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m_cnt[k][i] = 2;
            m_br[k] = 0;
            m_mp[k] = 0;
        end
        m_ghr = 0;
    endtask

    function automatic int m_idx(input int k);
        int base;
        base = int'((pc >> 2) & 32'hF);
        return (k == 1) ? (base ^ m_ghr) : base;
    endfunction

    // Compare every output of both instances against the model.
    task automatic check_all(input string tag);
        int          ix;
        logic [31:0] exp_addr;
        exp_addr = pc + off;
        for (int k = 0; k < 2; k++) begin
            ix = m_idx(k);
            check($sformatf("%s_%0d_idx", tag, k), 32'(k == 0 ? qidx_b : qidx_g), 32'(ix));
            check($sformatf("%s_%0d_pred", tag, k), 32'(k == 0 ? pred_b : pred_g),
                  32'(dec && m_cnt[k][ix] >= 2));
            check($sformatf("%s_%0d_addr", tag, k), (k == 0 ? addr_b : addr_g), exp_addr);
            check($sformatf("%s_%0d_br", tag, k), (k == 0 ? 32'(br_b) : 32'(br_g)), 32'(m_br[k]));
            check($sformatf("%s_%0d_mp", tag, k), (k == 0 ? 32'(mp_b) : 32'(mp_g)), 32'(m_mp[k]));
        end
    endtask

    task automatic model_update();
        int c;
        for (int k = 0; k < 2; k++) begin
            c = m_cnt[k][uidx];
            m_cnt[k][uidx] = act ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
            m_br[k] = (m_br[k] + 1) % m_mod[k];
            if (upred != act) m_mp[k] = (m_mp[k] + 1) % m_mod[k];
        end
        m_ghr = ((m_ghr << 1) | int'(act)) & 15;
    endtask

    // One cycle: drive after the falling edge, check before the rising edge.
    task automatic step(input string tag, input logic d, input logic [31:0] p,
                        input logic [31:0] o, input logic b, input logic a,
                        input logic [3:0] ui, input logic up);
        dec = d; pc = p; off = o; bm = b; act = a; uidx = ui; upred = up;
        #2;
        check_all(tag);
        @(posedge clk);
        if (b) model_update();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dec = 1'b0; pc = '0; off = '0; bm = 1'b0; act = 1'b0; uidx = '0; upred = 1'b0;
        model_reset();

        // Reset state and default prediction.
        dec = 1'b1; pc = 32'h100; off = 32'hFFFF_FFF0;
        #3;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        step("default", 1, 32'h100, 32'hFFFF_FFF0, 0, 0, 0, 0);
        check("default_addr_const", addr_b, 32'h0F0);
        check("default_pred_const", 32'(pred_b), 32'd1);

        // Saturation at idx 5: three not-taken, then taken steps up to and past ST.
        for (int i = 0; i < 3; i++) step("sat_dn", 1, 32'h14, 32'h8, 1, 0, 4'd5, 0);
        step("sat_lo", 1, 32'h14, 32'h8, 0, 0, 0, 0);
        check("sat_lo_const", 32'(pred_b), 32'd0);
        for (int i = 0; i < 4; i++) step("sat_up", 1, 32'h14, 32'h8, 1, 1, 4'd5, 0);
        step("sat_hi", 1, 32'h14, 32'h8, 1, 0, 4'd5, 0);
        step("sat_hi_after", 1, 32'h14, 32'h8, 0, 0, 0, 0);
        check("sat_hold3_const", 32'(pred_b), 32'd1);

        // Aliasing: idx 3 trained not-taken, shared by 0x0C and 0x4C; idx 4 untouched.
        for (int i = 0; i < 2; i++) step("alias_train", 0, 32'h0, 32'h0, 1, 0, 4'd3, 1);
        step("alias_0c", 1, 32'h0C, 32'h4, 0, 0, 0, 0);
        check("alias_0c_const", 32'(pred_b), 32'd0);
        step("alias_4c", 1, 32'h4C, 32'h4, 0, 0, 0, 0);
        check("alias_4c_const", 32'(pred_b), 32'd0);
        step("alias_idx4", 1, 32'h10, 32'h4, 0, 0, 0, 0);
        check("alias_idx4_const", 32'(pred_b), 32'd1);

        // Read-before-write on idx 2 (counter 2).
        dec = 1'b1; pc = 32'h8; off = 32'h0; bm = 1'b1; act = 1'b0; uidx = 4'd2; upred = 1'b1;
        #2;
        check("rbw_same_cycle", 32'(pred_b), 32'd1);
        @(negedge clk);
        model_update();
        step("rbw_next", 1, 32'h8, 32'h0, 0, 0, 0, 0);
        check("rbw_next_const", 32'(pred_b), 32'd0);

        // Gshare history: taken, taken, not-taken -> ghr 0110.
        pulse_reset();
        step("gh_t1", 0, 32'h0, 32'h0, 1, 1, 4'd15, 1);
        step("gh_t2", 0, 32'h0, 32'h0, 1, 1, 4'd15, 1);
        step("gh_nt", 0, 32'h0, 32'h0, 1, 0, 4'd15, 0);
        step("gh_query", 1, 32'h20, 32'h0, 0, 0, 0, 0);
        check("gh_idx_const", 32'(qidx_g), 32'hE);

        // Statistics wrap: 17 resolutions, 9 of them mispredicted.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            step("stat", 0, 32'h0, 32'h0, 1, 1'(i % 3 == 0), 4'(i),
                 (i % 2 == 0) ? 1'(i % 3 != 0) : 1'(i % 3 == 0));
        end
        step("stat_end", 0, 32'h0, 32'h0, 0, 0, 0, 0);
        check("stat_br_const", 32'(br_b), 32'd1);
        check("stat_mp_const", 32'(mp_b), 32'd9);

        // Asynchronous reset in the middle of an update cycle.
        for (int i = 0; i < 3; i++) step("pre_rst", 0, 32'h0, 32'h0, 1, 0, 4'd7, 1);
        dec = 1'b1; pc = 32'h1C; off = 32'h0; bm = 1'b1; act = 1'b0; uidx = 4'd7; upred = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        check("mid_rst_br_const", 32'(br_g), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1, 32'h1C, 32'h0, 0, 0, 0, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
